// File: rtl/mem.sv
// Byte-addressed 16-bit CPU memory port split across two 8-bit BRAM banks (even=lo, odd=hi).
// Width from ADDR_WIDTH; MEM_UNALIGNED_EN enables unaligned word accesses.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif

module mem (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [`ADDR_WIDTH-1:0]   addr,
  input  logic                     wr,
  input  logic                     byt,
  input  logic [15:0]              wr_data,
  output logic [15:0]              rd_data,
  output logic                     bram_clk,
  output logic                     bram_rst,
  output logic                     wr_lo,
  output logic                     wr_hi,
  output logic [`ADDR_WIDTH-2:0]   addr_lo,
  output logic [`ADDR_WIDTH-2:0]   addr_hi,
  output logic [7:0]               wr_data_lo,
  output logic [7:0]               wr_data_hi,
  input  logic [7:0]               rd_data_lo,
  input  logic [7:0]               rd_data_hi
);

  localparam int unsigned A  = `ADDR_WIDTH;
  localparam int unsigned BW = A - 1;

  logic [BW-1:0] idx_c;
  logic          unal_c;
  logic          swap_c;
  logic          byt_d, byt_q;
  logic          odd_d, odd_q;

  assign bram_clk = clk;
  assign bram_rst = rst;
  assign idx_c    = addr[A-1:1];

`ifdef MEM_UNALIGNED_EN
  assign unal_c = ~byt & addr[0];
  assign swap_c = ~byt_q & odd_q;
`else
  assign unal_c = 1'b0;
  assign swap_c = 1'b0;
`endif

  // Bank steering: an unaligned word starts in hi[i] and spills into lo[i+1]
  always_comb begin
    addr_hi    = idx_c;
    addr_lo    = idx_c + BW'(unal_c);
    wr_data_lo = wr_data[7:0];
    wr_data_hi = wr_data[15:8];
    wr_lo      = 1'b0;
    wr_hi      = 1'b0;
    if (byt) begin
      wr_data_hi = wr_data[7:0];
    end else if (unal_c) begin
      wr_data_lo = wr_data[15:8];
      wr_data_hi = wr_data[7:0];
    end
    if (wr && !rst) begin
      wr_lo = ~byt | ~addr[0];
      wr_hi = ~byt |  addr[0];
    end
  end

  assign byt_d = byt;
  assign odd_d = addr[0];

  // Read select tracks the BRAM's one-cycle output register
  always_ff @(posedge clk) begin
    if (rst) begin
      byt_q <= 1'b0;
      odd_q <= 1'b0;
    end else begin
      byt_q <= byt_d;
      odd_q <= odd_d;
    end
  end

  always_comb begin
    rd_data = {rd_data_hi, rd_data_lo};
    if (byt_q) begin
      rd_data = {8'h00, (odd_q ? rd_data_hi : rd_data_lo)};
    end else if (swap_c) begin
      rd_data = {rd_data_lo, rd_data_hi};
    end
  end

endmodule

// File: tb/tb_mem.sv
// Randomized scoreboard bench for mem: two BRAM bank models plus a flat byte-array reference.
// Honours MEM_UNALIGNED_EN the same way the design build does.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif

module tb_mem;

  localparam int unsigned A  = `ADDR_WIDTH;
  localparam int unsigned BW = A - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [A-1:0]  addr = '0;
  logic          wr = 1'b0;
  logic          byt = 1'b0;
  logic [15:0]   wr_data = '0;
  logic [15:0]   rd_data;
  logic          bram_clk, bram_rst;
  logic          wr_lo, wr_hi;
  logic [BW-1:0] addr_lo, addr_hi;
  logic [7:0]    wr_data_lo, wr_data_hi;
  logic [7:0]    rd_data_lo, rd_data_hi;

  mem dut (
    .clk(clk), .rst(rst), .addr(addr), .wr(wr), .byt(byt), .wr_data(wr_data),
    .rd_data(rd_data), .bram_clk(bram_clk), .bram_rst(bram_rst),
    .wr_lo(wr_lo), .wr_hi(wr_hi), .addr_lo(addr_lo), .addr_hi(addr_hi),
    .wr_data_lo(wr_data_lo), .wr_data_hi(wr_data_hi),
    .rd_data_lo(rd_data_lo), .rd_data_hi(rd_data_hi)
  );

  always #5 clk = ~clk;

  // BRAM banks: read-before-write, output register cleared by bram_rst
  logic [7:0] lo_mem [2**BW];
  logic [7:0] hi_mem [2**BW];
  always @(posedge bram_clk) begin
    if (bram_rst) begin
      rd_data_lo <= 8'h00;
      rd_data_hi <= 8'h00;
    end else begin
      rd_data_lo <= lo_mem[addr_lo];
      rd_data_hi <= hi_mem[addr_hi];
    end
    if (wr_lo) lo_mem[addr_lo] <= wr_data_lo;
    if (wr_hi) hi_mem[addr_hi] <= wr_data_hi;
  end

  logic [7:0]  ref_mem [2**A];
  logic [15:0] sb_q [$];
  logic [15:0] pend_exp;
  bit          pend = 1'b0;
  int          n_checks = 0;
  int          n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) chk("rd_data", 32'(rd_data), 32'(sb_q.pop_front()));
  end

  // One cycle of stimulus; the reference decides the read value before applying the write
  task automatic access(input logic [A-1:0] a, input logic w, input logic b,
                        input logic [15:0] wd, input logic r);
    logic          prev_rst;
    logic [A-1:0]  ea, a1;
    @(posedge clk);
    prev_rst = rst;
    if (pend) begin
      sb_q.push_back(pend_exp);
      pend = 1'b0;
    end
    #1;
    addr = a; wr = w; byt = b; wr_data = wd; rst = r;
    if (!r) begin
      ea = a;
`ifndef MEM_UNALIGNED_EN
      if (!b) ea[0] = 1'b0;
`endif
      a1 = A'(ea + 1);
      if (b) begin
        pend_exp = {8'h00, ref_mem[ea]};
        if (w) ref_mem[ea] = wd[7:0];
      end else begin
        pend_exp = {ref_mem[a1], ref_mem[ea]};
        if (w) begin
          ref_mem[ea] = wd[7:0];
          ref_mem[a1] = wd[15:8];
        end
      end
      pend = 1'b1;
    end
    #1;
    chk("wr_lo", 32'(wr_lo), 32'(w && !r && (!b || !a[0])));
    chk("wr_hi", 32'(wr_hi), 32'(w && !r && (!b ||  a[0])));
    if (prev_rst) chk("rd_after_rst", 32'(rd_data), 32'h0);
  endtask

  initial begin
    logic [A-1:0] ra;
    logic [A-1:0] top;
    top = '1;
    for (int i = 0; i < 2**A; i++) ref_mem[i] = 8'h00;
    for (int i = 0; i < 2**BW; i++) begin
      lo_mem[i] = 8'h00;
      hi_mem[i] = 8'h00;
    end

    access('0, 1'b0, 1'b0, 16'h0, 1'b1);
    access('0, 1'b0, 1'b0, 16'h0, 1'b1);

    // Aligned word write then read
    access(A'(16'h0300), 1'b1, 1'b0, 16'hBEEF, 1'b0);
    access(A'(16'h0300), 1'b0, 1'b0, 16'h0000, 1'b0);
    chk("lo_0x180", 32'(lo_mem[BW'(16'h0180)]), 32'hEF);
    chk("hi_0x180", 32'(hi_mem[BW'(16'h0180)]), 32'hBE);

    // Byte write to odd address, byte reads of both halves
    access(A'(16'h0301), 1'b1, 1'b1, 16'hAA41, 1'b0);
    access(A'(16'h0301), 1'b0, 1'b1, 16'h0000, 1'b0);
    access(A'(16'h0300), 1'b0, 1'b1, 16'h0000, 1'b0);
    chk("byte_hi_0x180", 32'(hi_mem[BW'(16'h0180)]), 32'h41);
    chk("byte_lo_kept", 32'(lo_mem[BW'(16'h0180)]), 32'hEF);

    // Word write at odd address
    access(A'(16'h0101), 1'b1, 1'b0, 16'h1234, 1'b0);
    access(A'(16'h0101), 1'b0, 1'b0, 16'h0000, 1'b0);
`ifdef MEM_UNALIGNED_EN
    chk("unal_hi_0x80", 32'(hi_mem[BW'(16'h0080)]), 32'h34);
    chk("unal_lo_0x81", 32'(lo_mem[BW'(16'h0081)]), 32'h12);
`else
    chk("al_lo_0x80", 32'(lo_mem[BW'(16'h0080)]), 32'h34);
    chk("al_hi_0x80", 32'(hi_mem[BW'(16'h0080)]), 32'h12);
`endif

    // Word at the very top address
    access(top, 1'b1, 1'b0, 16'hA5C3, 1'b0);
`ifdef MEM_UNALIGNED_EN
    chk("addr_lo_wrap", 32'(addr_lo), 32'h0);
`else
    chk("addr_lo_top", 32'(addr_lo), 32'(top[A-1:1]));
`endif
    chk("addr_hi_top", 32'(addr_hi), 32'(top[A-1:1]));
    access(top, 1'b0, 1'b0, 16'h0000, 1'b0);
    access(top, 1'b0, 1'b1, 16'h0000, 1'b0);

    // Writes under reset are dropped; reads afterwards see old data
    access(A'(16'h0300), 1'b1, 1'b0, 16'hDEAD, 1'b1);
    access(A'(16'h0300), 1'b1, 1'b1, 16'h00FF, 1'b1);
    access(A'(16'h0300), 1'b0, 1'b0, 16'h0000, 1'b0);
    chk("rst_drop_lo", 32'(lo_mem[BW'(16'h0180)]), 32'hEF);
    chk("rst_drop_hi", 32'(hi_mem[BW'(16'h0180)]), 32'h41);

    // Randomized traffic over a low window and a top window to force collisions and wrap
    for (int i = 0; i < 400; i++) begin
      ra = A'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) ra = A'(top - A'($urandom_range(0, 7)));
      access(ra, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             16'($urandom), 1'($urandom_range(0, 40) == 0));
    end

    access('0, 1'b0, 1'b0, 16'h0, 1'b0);
    access('0, 1'b0, 1'b0, 16'h0, 1'b0);
    @(posedge clk);
    if (pend) begin
      sb_q.push_back(pend_exp);
      pend = 1'b0;
    end
    @(negedge clk);
    @(negedge clk);
    if (sb_q.size() != 0) begin
      n_checks++;
      n_err++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
